// File: rtl/order_pkg.sv
// order_pkg: shared state encoding, default geometry and address-field width helpers for order_icache
package order_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  localparam int LINE_WORDS_D = 4;
  localparam int LINES_D = 16;
  function automatic int off_w(int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(int line_words, int lines);
    return 30 - $clog2(line_words) - $clog2(lines);
  endfunction
endpackage

// File: rtl/order_icache_if.sv
// order_icache_if: fetch-side read bus plus backing-memory word port of the instruction cache
interface order_icache_if;
  logic [31:0] add_bus;
  logic [31:0] data_bus;
  logic        isCplt;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  modport slave (
    input  add_bus, flush, mem_ack, mem_data,
    output data_bus, isCplt, mem_req, mem_addr
  );
  modport master (
    output add_bus, flush, mem_ack, mem_data,
    input  data_bus, isCplt, mem_req, mem_addr
  );
endinterface

// File: rtl/order_icache_store.sv
// order_icache_store: valid/tag/data arrays with a combinational read port and a synchronous write port
module order_icache_store
  import order_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_D,
  parameter int LINES = LINES_D,
  localparam int OFF = off_w(LINE_WORDS),
  localparam int IDX = idx_w(LINES),
  localparam int TAG = tag_w(LINE_WORDS, LINES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [IDX-1:0] rd_idx,
  input  logic [OFF-1:0] rd_off,
  output logic           rd_valid,
  output logic [TAG-1:0] rd_tag,
  output logic [31:0]    rd_word,
  input  logic           we,
  input  logic [IDX-1:0] wr_idx,
  input  logic [OFF-1:0] wr_off,
  input  logic [31:0]    wr_word,
  input  logic           tag_we,
  input  logic [TAG-1:0] wr_tag,
  input  logic           set_valid
);
  logic [LINES-1:0] valid;
  logic [TAG-1:0]   tags [LINES];
  logic [31:0]      data [LINES][LINE_WORDS];
  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = data[rd_idx][rd_off];
  // valid bits: cleared by reset or flush, set when a clean fill completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (clr) valid <= '0;
    else if (set_valid) valid[wr_idx] <= 1'b1;
  // data and tag arrays carry no reset; a line is only trusted once its valid bit is set
  always_ff @(posedge clk) begin
    if (we) data[wr_idx][wr_off] <= wr_word;
    if (tag_we) tags[wr_idx] <= wr_tag;
  end
endmodule

// File: rtl/order_icache.sv
// order_icache: direct-mapped instruction cache answering fetch reads, refilling whole lines on a miss
module order_icache
  import order_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_D,
  parameter int LINES = LINES_D
) (
  input logic            clk,
  input logic            rst_n,
  order_icache_if.slave  bus
);
  localparam int OFF = off_w(LINE_WORDS);
  localparam int IDX = idx_w(LINES);
  localparam int TAG = tag_w(LINE_WORDS, LINES);
  logic [0:0]     state;
  logic [OFF-1:0] cnt;
  logic [29-OFF:0] base;
  logic           flush_pend;
  logic           rd_valid;
  logic [TAG-1:0] rd_tag;
  logic [31:0]    rd_word;
  logic           hit;
  logic           ack;
  logic           last;
  assign ack  = state == FILL && bus.mem_ack;
  assign last = ack && &cnt;
  assign hit  = state == IDLE && rd_valid && rd_tag == bus.add_bus[31:OFF+IDX+2] && !bus.flush;
  assign bus.isCplt   = hit;
  assign bus.data_bus = hit ? rd_word : '0;
  assign bus.mem_req  = state == FILL;
  assign bus.mem_addr = state == FILL ? {base, cnt, 2'b00} : '0;
  // miss handling: latch the line base, fetch its words in order, then return to lookup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      flush_pend <= 1'b0;
    end else if (state == IDLE) begin
      if (!hit) begin
        state <= FILL;
        base <= bus.add_bus[31:OFF+2];
        cnt <= '0;
      end
    end else begin
      if (bus.flush) flush_pend <= 1'b1;
      if (ack) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= IDLE;
          flush_pend <= 1'b0;
        end
      end
    end
  order_icache_store #(.LINE_WORDS(LINE_WORDS), .LINES(LINES)) store (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.flush),
    .rd_idx(bus.add_bus[OFF+IDX+1:OFF+2]),
    .rd_off(bus.add_bus[OFF+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_word(rd_word),
    .we(ack),
    .wr_idx(base[IDX-1:0]),
    .wr_off(cnt),
    .wr_word(bus.mem_data),
    .tag_we(last),
    .wr_tag(base[29-OFF:IDX]),
    .set_valid(last && !flush_pend && !bus.flush)
  );
endmodule
